// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core: stall sequencing,
// forwarding select, IF/ID flush and stall/flush performance counters.
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_Beq,
    input  logic             ID_Jump,
    input  logic             branch,
    input  logic [4:0]       ID_EX_Rd,
    input  logic             ID_EX_RegWrite,
    input  logic             ID_EX_Mem2Reg,
    input  logic [4:0]       EX_MEM_Rd,
    input  logic             EX_MEM_RegWrite,
    input  logic             EX_MEM_Mem2Reg,
    input  logic [4:0]       MEM_WB_Rd,
    input  logic             MEM_WB_RegWrite,
    output logic             stall,
    output logic             PC_en,
    output logic             IF_ID_en,
    output logic             IF_ID_flush,
    output logic [3:0]       forwardSignal,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             dbg_in_stall
);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_STALL = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] remain_q, remain_d;
    logic       stall_raw;

    // Register-match terms; register 0 is hardwired and never a dependency.
    logic ex_hit_rs, ex_hit_rt, ex_hit;
    logic mem_hit_rs, mem_hit_rt, mem_hit;
    logic wb_hit_rs, wb_hit_rt;

    assign ex_hit_rs  = ID_EX_RegWrite  & (ID_EX_Rd  != 5'd0) & (ID_EX_Rd  == ID_Rs);
    assign ex_hit_rt  = ID_EX_RegWrite  & (ID_EX_Rd  != 5'd0) & (ID_EX_Rd  == ID_Rt);
    assign mem_hit_rs = EX_MEM_RegWrite & (EX_MEM_Rd != 5'd0) & (EX_MEM_Rd == ID_Rs);
    assign mem_hit_rt = EX_MEM_RegWrite & (EX_MEM_Rd != 5'd0) & (EX_MEM_Rd == ID_Rt);
    assign wb_hit_rs  = MEM_WB_RegWrite & (MEM_WB_Rd != 5'd0) & (MEM_WB_Rd == ID_Rs);
    assign wb_hit_rt  = MEM_WB_RegWrite & (MEM_WB_Rd != 5'd0) & (MEM_WB_Rd == ID_Rt);
    assign ex_hit     = ex_hit_rs | ex_hit_rt;
    assign mem_hit    = mem_hit_rs | mem_hit_rt;

    logic haz_br_load, haz_br_load_ex, haz_br_alu, haz_load_use;
    logic hazard, hazard_deep;

    assign haz_br_load    =  ID_Beq & mem_hit & EX_MEM_Mem2Reg;
    assign haz_br_load_ex =  ID_Beq & ex_hit  & ID_EX_Mem2Reg;
    assign haz_br_alu     =  ID_Beq & ex_hit  & ~ID_EX_Mem2Reg;
    assign haz_load_use   = ~ID_Beq & ex_hit  & ID_EX_Mem2Reg;
    assign hazard         = haz_br_load | haz_br_load_ex | haz_br_alu | haz_load_use;
    // BR_LOAD outranks BR_LOAD_EX, so the two-cycle stall only applies when it is the winner.
    assign hazard_deep    = haz_br_load_ex & ~haz_br_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RUN;
            remain_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        remain_d  = remain_q;
        stall_raw = 1'b0;
        case (state_q)
            S_RUN: begin
                if (hazard) begin
                    stall_raw = 1'b1;
                    if (hazard_deep) begin
                        state_d  = S_STALL;
                        remain_d = 2'd1;
                    end
                end
            end
            S_STALL: begin
                stall_raw = 1'b1;
                if (remain_q <= 2'd1) begin
                    state_d  = S_RUN;
                    remain_d = 2'd0;
                end else begin
                    remain_d = remain_q - 2'd1;
                end
            end
            default: begin
                state_d  = S_RUN;
                remain_d = 2'd0;
            end
        endcase
    end

    function automatic logic [1:0] fwd_sel(input logic mem_hit_r, input logic wb_hit_r);
        if (mem_hit_r & ~EX_MEM_Mem2Reg) return 2'b01;
        else if (wb_hit_r)               return 2'b10;
        else                             return 2'b00;
    endfunction

    // Outputs are forced quiet during the reset cycle regardless of inputs.
    assign stall         = ~rst & stall_raw;
    assign PC_en         = ~stall;
    assign IF_ID_en      = ~stall;
    assign IF_ID_flush   = ~rst & ~stall & ((ID_Beq & branch) | ID_Jump);
    assign forwardSignal = rst ? 4'b0000
                               : {fwd_sel(mem_hit_rs, wb_hit_rs), fwd_sel(mem_hit_rt, wb_hit_rt)};
    assign dbg_in_stall  = (state_q == S_STALL);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall)       stall_count <= stall_count + CNT_W'(1);
            if (IF_ID_flush) flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule
